// File: rtl/formant_smoother.sv
// Formant frequency smoother: scales per-formant angles to Hz, then runs a
// jump-rejecting first-order tracker per formant before presenting the frame.
module formant_smoother #(
  parameter int unsigned BIT_WIDTH   = 32,
  parameter int unsigned FORMANTS    = 4,
  parameter int unsigned SCALE_Q16   = 104303783,
  parameter int unsigned ALPHA_SHIFT = 2,
  parameter int unsigned JUMP_LIMIT  = 500,
  parameter int unsigned REJECT_MAX  = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] in_phi [0:FORMANTS-1],
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_hz [0:FORMANTS-1],
  output logic [7:0]           drop_count
);
  localparam int unsigned W  = BIT_WIDTH;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned DW = W + 1;
  localparam int unsigned SW = W + 2;
  localparam int unsigned KW = (FORMANTS > 1) ? $clog2(FORMANTS) : 1;
  localparam int unsigned RW = (REJECT_MAX > 1) ? $clog2(REJECT_MAX + 1) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(FORMANTS - 1);

  typedef enum logic [1:0] {IDLE, SCALE, FILTER, OUTPUT} state_t;

  state_t               state, state_nx;
  logic [KW-1:0]        k;
  logic                 primed;
  logic [W-1:0]         phi_q [0:FORMANTS-1];
  logic [W-1:0]         hz_q  [0:FORMANTS-1];
  logic [W-1:0]         track [0:FORMANTS-1];
  logic [RW-1:0]        rej   [0:FORMANTS-1];

  logic [PW-1:0]        prod, prod_sh;
  logic [W-1:0]         hz_scaled;
  logic signed [DW-1:0] diff, step;
  logic [DW-1:0]        mag;
  logic signed [SW-1:0] sum;
  logic [W-1:0]         smoothed, track_upd;
  logic [RW-1:0]        rej_upd;

  assign out_hz = track;

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == OUTPUT);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SCALE;
      SCALE:   if (k == K_LAST) state_nx = FILTER;
      FILTER:  if (k == K_LAST) state_nx = OUTPUT;
      OUTPUT:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Angle-to-Hz scaling of formant k, saturating when the result overflows W bits.
  always_comb begin
    prod      = PW'(phi_q[k]) * PW'(SCALE_Q16);
    prod_sh   = prod >> 16;
    hz_scaled = (|prod_sh[PW-1:W]) ? '1 : prod_sh[W-1:0];
  end

  // Tracker update for formant k; the sum is clamped so the track never wraps.
  always_comb begin
    diff      = $signed({1'b0, hz_q[k]}) - $signed({1'b0, track[k]});
    mag       = diff[W] ? DW'(-diff) : DW'(diff);
    step      = diff >>> ALPHA_SHIFT;
    sum       = $signed({2'b00, track[k]}) + SW'(step);
    smoothed  = sum[SW-1] ? '0 : (sum[W] ? '1 : sum[W-1:0]);
    track_upd = track[k];
    rej_upd   = '0;
    if (!primed) begin
      track_upd = hz_q[k];
    end else if (mag <= DW'(JUMP_LIMIT)) begin
      track_upd = smoothed;
    end else if ((32'(rej[k]) + 32'd1) >= REJECT_MAX) begin
      track_upd = hz_q[k];
    end else begin
      rej_upd = rej[k] + RW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      k          <= '0;
      primed     <= 1'b0;
      drop_count <= '0;
      for (int i = 0; i < FORMANTS; i++) begin
        phi_q[i] <= '0;
        hz_q[i]  <= '0;
        track[i] <= '0;
        rej[i]   <= '0;
      end
    end else begin
      if (in_valid && (state != IDLE) && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
      case (state)
        IDLE: begin
          if (in_valid) begin
            phi_q <= in_phi;
            k     <= '0;
          end
        end
        SCALE: begin
          hz_q[k] <= hz_scaled;
          k       <= (k == K_LAST) ? '0 : k + KW'(1);
        end
        FILTER: begin
          track[k] <= track_upd;
          rej[k]   <= rej_upd;
          if (k == K_LAST) begin
            k      <= '0;
            primed <= 1'b1;
          end else begin
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_formant_smoother.sv
// Bench for formant_smoother: two instances (default scale, and unity scale so
// hz equals phi) checked every cycle against a frame-level reference model.
module tb_formant_smoother;
  localparam int unsigned W   = 32;
  localparam int unsigned F   = 4;
  localparam int unsigned LAT = 2 * F + 1;
  localparam longint unsigned MAXV    = 64'hFFFF_FFFF;
  localparam longint unsigned SCALE_A = 104303783;
  localparam longint unsigned SCALE_B = 65536;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic         rst_in, in_valid, out_ready;
  logic [W-1:0] phi_a [0:F-1];
  logic [W-1:0] phi_b [0:F-1];
  logic [W-1:0] hz_a  [0:F-1];
  logic [W-1:0] hz_b  [0:F-1];
  logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [7:0]   drop_a, drop_b;

  formant_smoother dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_phi(phi_a),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_hz(hz_a), .drop_count(drop_a)
  );

  formant_smoother #(.SCALE_Q16(65536)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_phi(phi_b),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_hz(hz_b), .drop_count(drop_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-lane tracker plus frame-level handshake timing.
  longint unsigned m_track [2][F];
  int              m_rej   [2][F];
  bit              m_primed [2];
  bit              m_busy, m_ovalid;
  int              m_wait, m_drops;

  function automatic longint unsigned ideal_hz(input longint unsigned phi,
                                               input longint unsigned scale);
    longint unsigned p;
    p = (phi * scale) >> 16;
    return (p > MAXV) ? MAXV : p;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_primed[l] = 1'b0;
      for (int k = 0; k < F; k++) begin
        m_track[l][k] = 0;
        m_rej[l][k]   = 0;
      end
    end
    m_busy = 1'b0; m_ovalid = 1'b0; m_wait = 0; m_drops = 0;
  endtask

  task automatic model_frame();
    longint unsigned hz;
    longint d, t;
    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < F; k++) begin
        if (l == 0) hz = ideal_hz(64'(phi_a[k]), SCALE_A);
        else        hz = ideal_hz(64'(phi_b[k]), SCALE_B);
        d = longint'(hz) - longint'(m_track[l][k]);
        if (!m_primed[l]) begin
          m_track[l][k] = hz; m_rej[l][k] = 0;
        end else if (d >= -500 && d <= 500) begin
          t = longint'(m_track[l][k]) + (d >>> 2);
          if (t < 0) t = 0;
          if (t > longint'(MAXV)) t = longint'(MAXV);
          m_track[l][k] = unsigned'(t); m_rej[l][k] = 0;
        end else if (m_rej[l][k] + 1 >= 2) begin
          m_track[l][k] = hz; m_rej[l][k] = 0;
        end else begin
          m_rej[l][k] = m_rej[l][k] + 1;
        end
      end
      m_primed[l] = 1'b1;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    if (!m_busy) begin
      if (in_valid) begin
        model_frame();
        m_busy = 1'b1;
        m_wait = LAT - 1;
      end
    end else begin
      if (in_valid && m_drops < 255) m_drops++;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_ovalid = 1'b1;
      end else if (m_ovalid && out_ready) begin
        m_busy = 1'b0; m_ovalid = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input longint unsigned act,
                     input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("in_ready_a", 64'(in_ready_a), 64'(!m_busy));
    chk("in_ready_b", 64'(in_ready_b), 64'(!m_busy));
    chk("out_valid_a", 64'(out_valid_a), 64'(m_ovalid));
    chk("out_valid_b", 64'(out_valid_b), 64'(m_ovalid));
    chk("drop_count_a", 64'(drop_a), 64'(m_drops));
    chk("drop_count_b", 64'(drop_b), 64'(m_drops));
    if (!rst_in || m_ovalid) begin
      for (int k = 0; k < F; k++) begin
        chk($sformatf("out_hz_a[%0d]", k), 64'(hz_a[k]), m_track[0][k]);
        chk($sformatf("out_hz_b[%0d]", k), 64'(hz_b[k]), m_track[1][k]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    if (rst_in) model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) tick();
    rst_in = 1'b1;
  endtask

  task automatic load_phi(input logic [W-1:0] pa, input logic [W-1:0] pb);
    for (int k = 0; k < F; k++) begin
      phi_a[k] = pa;
      phi_b[k] = pb;
    end
  endtask

  // One frame with out_ready high; optionally pins every lane to literal values.
  task automatic send(input logic [W-1:0] pa, input logic [W-1:0] pb, input bit pin,
                      input logic [W-1:0] ea, input logic [W-1:0] eb);
    int n;
    load_phi(pa, pb);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (n < 40 && !out_valid_a) begin tick(); n++; end
    chk("frame_latency", 64'(n + 1), 64'(LAT));
    if (pin) begin
      for (int k = 0; k < F; k++) begin
        chk($sformatf("pin_a[%0d]", k), 64'(hz_a[k]), 64'(ea));
        chk($sformatf("pin_b[%0d]", k), 64'(hz_b[k]), 64'(eb));
      end
    end
    tick();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (n < 40 && !out_valid_a) begin tick(); n++; end
    chk("wait_out_valid", 64'(out_valid_a), 64'd1);
  endtask

  initial begin
    longint t;
    int r;
    rst_in = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    load_phi('0, '0);
    model_reset();
    #2;
    do_reset();

    // First frame unfiltered, then smoothing, then reject-then-accept of a jump.
    send(32'd1, 32'd1591, 1'b1, 32'd1591, 32'd1591);
    send(32'd1, 32'd2000, 1'b1, 32'd1591, 32'd1693);
    send(32'd4, 32'd5000, 1'b1, 32'd1591, 32'd1693);
    send(32'd4, 32'd5000, 1'b1, 32'd6366, 32'd5000);

    // Saturated scaling and no wrap near the top of the range.
    do_reset();
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(32'hFFFF_FFFF, 32'hFFFF_FFE0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF7);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

    // Consumer stalls while three frames are offered.
    do_reset();
    load_phi(32'd2, 32'd700);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      in_valid = (i == 2 || i == 7 || i == 13);
      tick();
    end
    in_valid = 1'b0;
    chk("stall_drops_a", 64'(drop_a), 64'd3);
    chk("stall_drops_b", 64'(drop_b), 64'd3);
    chk("stall_held", 64'(out_valid_a), 64'd1);
    chk("stall_hz_b0", 64'(hz_b[0]), 64'd700);
    out_ready = 1'b1;
    tick();
    chk("stall_release", 64'(out_valid_a), 64'd0);

    // Reset in the middle of filtering, then an unfiltered first frame.
    send(32'd1, 32'd1500, 1'b0, '0, '0);
    load_phi(32'd3, 32'd1600);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (F + 1) tick();
    do_reset();
    repeat (LAT + 2) tick();
    send(32'd1, 32'd3000, 1'b1, 32'd1591, 32'd3000);

    // Drop counter saturation.
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (300) tick();
    chk("drop_sat_a", 64'(drop_a), 64'd255);
    chk("drop_sat_b", 64'(drop_b), 64'd255);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        in_valid  = ($urandom_range(0, 2) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < F; k++) begin
          r = int'($urandom_range(0, 15));
          if (r == 0)     phi_a[k] = '1;
          else if (r < 6) phi_a[k] = $urandom();
          else            phi_a[k] = W'($urandom_range(0, 8));
          r = int'($urandom_range(0, 15));
          if (r == 0) begin
            phi_b[k] = '1;
          end else if (r < 3) begin
            phi_b[k] = $urandom();
          end else begin
            t = longint'(m_track[1][k]) + longint'($urandom_range(0, 1400)) - 700;
            if (t < 0) t = 0;
            if (t > longint'(MAXV)) t = longint'(MAXV);
            phi_b[k] = W'(t);
          end
        end
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
